mul_tree_sched: RTL
===================

// Module: mul_tree_sched
// PURPOSE
//  Shares one combinational 4:2-compressor multiplier tree among NUM_REQ requesters.
//  Round-robin arbiter accepts one operand pair per cycle, drives it to the tree, and
//  carries product + requester tag through a PIPE_STAGES-deep result pipeline.
//  Single tagged response port with valid/ready backpressure; stalls the whole pipeline.
// PARAMETERS
//  DATA_LEN     8  operand width; product is 2*DATA_LEN
//  NUM_REQ      4  number of requesters (>=2); TAG_W = $clog2(NUM_REQ)
//  PIPE_STAGES  2  result register stages after the tree (>=1)
// PORTS
//  clk         in   1                   clock, all state on posedge
//  rst         in   1                   synchronous, active-high reset
//  req_valid   in   NUM_REQ             requester i has operands pending
//  req_ready   out  NUM_REQ             one-hot (or 0): requester i accepted this cycle
//  req_op1     in   NUM_REQ*DATA_LEN    multiplicand per requester, [i*DATA_LEN +: DATA_LEN]
//  req_op2     in   NUM_REQ*DATA_LEN    multiplier per requester
//  mul_op1     out  DATA_LEN            registered operand to tree
//  mul_op2     out  DATA_LEN            registered operand to tree
//  mul_prod    in   2*DATA_LEN          tree product, combinational from mul_op1/mul_op2
//  resp_valid  out  1                   response available
//  resp_ready  in   1                   consumer accepts response
//  resp_tag    out  TAG_W               requester index of response
//  resp_prod   out  2*DATA_LEN          unsigned product
//  inflight    out  $clog2(PIPE_STAGES+2)  ops accepted but not yet responded
// BEHAVIOUR
//  - Reset (sync, rst=1 at posedge): all stage valids=0, resp_valid=0, resp_tag=0,
//    resp_prod=0, mul_op1/2=0, inflight=0, rr pointer=NUM_REQ-1 (req 0 highest first).
//  - advance = !resp_valid | resp_ready. When advance=0, every stage holds.
//  - Stage 0 (operand reg) -> stages 1..PIPE_STAGES (product+tag); stage PIPE_STAGES
//    drives resp_*. On advance: s0 <- accepted request (or bubble), s1 <- {mul_prod,
//    s0.tag, s0.v}, sK <- s(K-1).
//  - Arbitration (comb): grant = first i with req_valid[i] scanning ptr+1, ptr+2, ...
//    mod NUM_REQ. req_ready = grant & {NUM_REQ{advance}}. No grant when no valid.
//  - Handshake: accept iff req_valid[i] & req_ready[i]; ptr <- i on accept only.
//    Requester must hold valid/operands until accepted; no combinational path
//    req_valid -> resp_*.
//  - Latency: accepted at edge T, no stall -> resp_valid=1 in the cycle after edge
//    T+PIPE_STAGES (PIPE_STAGES+1 cycles). Each stall cycle adds one cycle.
//  - Throughput 1 op/cycle with resp_ready=1; back-to-back grants to same requester
//    only if it is the sole valid requester.
//  - resp_* stable while resp_valid & !resp_ready. Bubble stages do not stall:
//    a valid stage behind a bubble still moves when advance=1.
//  - inflight: +1 on accept, -1 on resp_valid&resp_ready, both same cycle -> unchanged;
//    max PIPE_STAGES+1, never wraps.
//  - Reset mid-operation: all in-flight ops dropped, no response emitted for them.
//  - Product = unsigned op1*op2 exactly as returned on mul_prod; block does no math.
// TESTING
//  1 Single op: req_valid=4'b0001, op1=8'd13, op2=8'd11 -> req_ready[0] 1 cycle,
//    resp_valid after 3 cycles (PIPE_STAGES=2), resp_tag=0, resp_prod=16'd143.
//  2 Fairness: all 4 valid continuously, resp_ready=1 -> grants 0,1,2,3,0,...;
//    tags in same order; 255*255=16'hFE01 from req 3 tagged 3.
//  3 Backpressure: fill pipe, resp_ready=0 for 5 cycles -> req_ready=0, resp_* stable,
//    inflight=3; release -> responses drain in order, none lost or duplicated.
//  4 Bubbles: req 2 valid on alternating cycles -> responses with gaps, order kept,
//    inflight never exceeds 3, returns to 0.
//  5 Reset mid-flight: 3 ops in flight, rst=1 one cycle -> next cycle resp_valid=0,
//    inflight=0, ptr reset (req 0 granted first afterwards).
//  6 Simultaneous accept+retire with resp_ready=1: inflight holds; 0*x -> 0 product.

Source files
------------

// File: rtl/mul_tree_sched.sv
// Round-robin front end that time-shares one external combinational multiplier tree
// among NUM_REQ requesters and returns tagged products through a stallable pipeline.
module mul_tree_sched #(
   parameter  int DATA_LEN    = 8,
   parameter  int NUM_REQ     = 4,
   parameter  int PIPE_STAGES = 2,
   localparam int TAG_W       = $clog2(NUM_REQ),
   localparam int INF_W       = $clog2(PIPE_STAGES + 2)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_REQ-1:0]           req_valid,
   output logic [NUM_REQ-1:0]           req_ready,
   input  logic [NUM_REQ*DATA_LEN-1:0]  req_op1,
   input  logic [NUM_REQ*DATA_LEN-1:0]  req_op2,
   output logic [DATA_LEN-1:0]          mul_op1,
   output logic [DATA_LEN-1:0]          mul_op2,
   input  logic [2*DATA_LEN-1:0]        mul_prod,
   output logic                         resp_valid,
   input  logic                         resp_ready,
   output logic [TAG_W-1:0]             resp_tag,
   output logic [2*DATA_LEN-1:0]        resp_prod,
   output logic [INF_W-1:0]             inflight
);

   logic                   advance;
   logic                   accept;
   logic                   retire;
   logic                   found;
   logic [NUM_REQ-1:0]     grant;
   logic [TAG_W-1:0]       grant_idx;
   logic [TAG_W-1:0]       cand [NUM_REQ];
   logic [TAG_W-1:0]       ptr;

   logic                   s0_valid;
   logic [TAG_W-1:0]       s0_tag;
   logic [PIPE_STAGES:1]   st_valid;
   logic [TAG_W-1:0]       st_tag  [1:PIPE_STAGES];
   logic [2*DATA_LEN-1:0]  st_prod [1:PIPE_STAGES];

   // A full output stage that is not being taken freezes everything, bubbles included.
   assign advance    = !resp_valid || resp_ready;
   assign req_ready  = grant & {NUM_REQ{advance}};
   assign accept     = found && advance;
   assign retire     = resp_valid && resp_ready;

   assign resp_valid = st_valid[PIPE_STAGES];
   assign resp_tag   = st_tag[PIPE_STAGES];
   assign resp_prod  = st_prod[PIPE_STAGES];

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (int'(ptr) + k + 1 >= NUM_REQ)
            cand[k] = TAG_W'(int'(ptr) + k + 1 - NUM_REQ);
         else
            cand[k] = TAG_W'(int'(ptr) + k + 1);
      end
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!found && req_valid[cand[k]]) begin
            found           = 1'b1;
            grant_idx       = cand[k];
            grant[cand[k]]  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr      <= TAG_W'(NUM_REQ - 1);
         s0_valid <= 1'b0;
         s0_tag   <= '0;
         mul_op1  <= '0;
         mul_op2  <= '0;
         for (int k = 1; k <= PIPE_STAGES; k++) begin
            st_valid[k] <= 1'b0;
            st_tag[k]   <= '0;
            st_prod[k]  <= '0;
         end
      end else if (advance) begin
         s0_valid <= accept;
         if (accept) begin
            ptr     <= grant_idx;
            s0_tag  <= grant_idx;
            mul_op1 <= req_op1[grant_idx*DATA_LEN +: DATA_LEN];
            mul_op2 <= req_op2[grant_idx*DATA_LEN +: DATA_LEN];
         end
         st_valid[1] <= s0_valid;
         st_tag[1]   <= s0_tag;
         st_prod[1]  <= mul_prod;
         for (int k = 2; k <= PIPE_STAGES; k++) begin
            st_valid[k] <= st_valid[k-1];
            st_tag[k]   <= st_tag[k-1];
            st_prod[k]  <= st_prod[k-1];
         end
      end
   end

   // Bounded by construction: at most one op per stage, so it never exceeds PIPE_STAGES+1.
   always_ff @(posedge clk) begin
      if (rst)
         inflight <= '0;
      else if (accept && !retire)
         inflight <= inflight + INF_W'(1);
      else if (!accept && retire)
         inflight <= inflight - INF_W'(1);
   end

endmodule
